// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply-divide unit:
// M-extension func3 codes, FSM states and decode helpers.
package muldiv_pkg;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the execute stage
// and the multiply-divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, func3, rs1, rs2,
    output flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, func3, rs1, rs2,
    input  flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring
// trial-subtract for divide, on a {hi, lo} accumulator.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  always_comb begin
    sum   = {1'b0, acc[2*XLEN-1:XLEN]}
          + {1'b0, (acc[0] ? opnd : '0)};
    trial = acc[2*XLEN-1:XLEN-1];
    diff  = trial - {1'b0, opnd};
    acc_next = {sum, acc[XLEN-1:1]};
    if (div) begin
      // borrow out of bit XLEN means the trial subtract went negative
      if (diff[XLEN])
        acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: magnitudes in, UNROLL radix-2 steps per
// CALC cycle, sign fixup, registered result behind valid/ready.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic     clk,
  input logic     rstn,
  muldiv_if.slave bus
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N);

  if (!(XLEN == 32 || XLEN == 64) ||
      !(UNROLL == 1 || UNROLL == 2 || UNROLL == 4) ||
      (XLEN % UNROLL) != 0) begin : g_bad_cfg
    $error("muldiv_unit: unsupported XLEN/UNROLL");
  end

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   res;
  logic [2:0]        op;
  logic              neg_q, neg_r;

  logic            accept, fast, dz, ovf;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem, fix_res;
  logic            op_div;

  logic [2*XLEN-1:0] chain [UNROLL+1];

  always_comb begin
    a_sgn = 1'b1;
    b_sgn = 1'b1;
    unique case (bus.func3)
      M_MULHSU: b_sgn = 1'b0;
      M_MULHU, M_DIVU, M_REMU: begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
      end
      default: ;
    endcase
    a_neg = a_sgn & bus.rs1[XLEN-1];
    b_neg = b_sgn & bus.rs2[XLEN-1];
    a_mag = a_neg ? -bus.rs1 : bus.rs1;
    b_mag = b_neg ? -bus.rs2 : bus.rs2;
    dz    = (bus.rs2 == '0);
    ovf   = a_sgn & is_div(bus.func3)
          & (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}})
          & (&bus.rs2);
    fast  = is_div(bus.func3) & (dz | ovf);
    if (!bus.func3[1])
      fast_res = dz ? '1 : bus.rs1;
    else
      fast_res = dz ? bus.rs1 : '0;
    accept = (state == S_IDLE) & bus.in_valid & ~bus.flush;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = fast ? S_DONE : S_CALC;
      S_CALC:  if (cnt == '0) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  assign op_div   = is_div(op);
  assign chain[0] = acc;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .div      (op_div),
      .acc      (chain[i]),
      .opnd     (opnd),
      .acc_next (chain[i+1])
    );
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_res = '0;
    unique case (1'b1)
      (op == M_MUL):             fix_res = prod[XLEN-1:0];
      (!op[2] && op != M_MUL):   fix_res = prod[2*XLEN-1:XLEN];
      (op[2] && !op[1]):         fix_res = quo;
      (op[2] && op[1]):          fix_res = rem;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      res   <= '0;
      op    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          op    <= bus.func3;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= CW'(N - 1);
          if (fast) begin
            res <= fast_res;
          end else if (is_div(bus.func3)) begin
            acc  <= {{XLEN{1'b0}}, a_mag};
            opnd <= b_mag;
          end else begin
            acc  <= {{XLEN{1'b0}}, b_mag};
            opnd <= a_mag;
          end
        end
        S_CALC: begin
          acc <= chain[UNROLL];
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_FIXUP: res <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = res;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: UNROLL=1 and UNROLL=4 instances checked
// against a plain-arithmetic M-extension model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rstn1, rstn4;

  muldiv_if #(.XLEN(32)) b1 ();
  muldiv_if #(.XLEN(32)) b4 ();

  muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (
    .clk  (clk),
    .rstn (rstn1),
    .bus  (b1.slave)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (
    .clk  (clk),
    .rstn (rstn4),
    .bus  (b4.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic logic [31:0] model(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f)
      M_MUL:    begin p = sa * sb; return p[31:0]; end
      M_MULH:   begin p = sa * sb; return p[63:32]; end
      M_MULHSU: begin p = sa * ub; return p[63:32]; end
      M_MULHU:  begin p = ua * ub; return p[63:32]; end
      M_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb;
        return p[31:0];
      end
      M_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      M_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
    input int n);
    if (f[2] && (b == 0 ||
        (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return n + 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input bit sel, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (sel) begin
      b4.func3 = f; b4.rs1 = a; b4.rs2 = b; b4.in_valid = 1'b1;
    end else begin
      b1.func3 = f; b1.rs1 = a; b1.rs2 = b; b1.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
    b4.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, output int lat);
    lat = 1;
    while (!(sel ? b4.out_valid : b1.out_valid) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take(input bit sel);
    @(negedge clk);
    if (sel) b4.out_ready = 1'b1;
    else     b1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b1.out_ready = 1'b0;
    b4.out_ready = 1'b0;
  endtask

  task automatic run(input bit sel, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] r, output int lat);
    launch(sel, f, a, b);
    wait_valid(sel, lat);
    r = sel ? b4.result : b1.result;
    take(sel);
  endtask

  task automatic rand_ops(input bit sel, input int n, input int cnt);
    logic [2:0]  f;
    logic [31:0] a, b, r;
    int lat;
    for (int i = 0; i < cnt; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin
          b = 32'hFFFF_FFFF;
          if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
        end
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run(sel, f, a, b, r, lat);
      chk($sformatf("rnd%0d_u%0d_f%0d_res", i, sel ? 4 : 1, f),
          r, model(f, a, b));
      chk($sformatf("rnd%0d_u%0d_lat", i, sel ? 4 : 1),
          lat, exp_lat(f, a, b, n));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    logic [31:0] r;
    int lat;
    bit seen;

    vt[0]  = '{M_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vt[1]  = '{M_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vt[2]  = '{M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vt[3]  = '{M_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vt[4]  = '{M_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
    vt[5]  = '{M_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
    vt[6]  = '{M_DIVU,   32'd100,       32'd7,         32'd14,        34};
    vt[7]  = '{M_REMU,   32'd100,       32'd7,         32'd2,         34};
    vt[8]  = '{M_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vt[9]  = '{M_REM,    32'd5,         32'd0,         32'd5,         1};
    vt[10] = '{M_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vt[11] = '{M_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};

    b1.in_valid = 0; b1.func3 = 0; b1.rs1 = 0; b1.rs2 = 0;
    b1.flush = 0; b1.out_ready = 0;
    b4.in_valid = 0; b4.func3 = 0; b4.rs1 = 0; b4.rs2 = 0;
    b4.flush = 0; b4.out_ready = 0;
    rstn1 = 0;
    rstn4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn1 = 1;
    rstn4 = 1;
    #1;
    chk("rst_in_ready", b1.in_ready, 1);
    chk("rst_out_valid", b1.out_valid, 0);
    chk("rst_result", b1.result, 0);
    chk("rst_u4_in_ready", b4.in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      run(0, vt[i].f, vt[i].a, vt[i].b, r, lat);
      chk($sformatf("vec%0d_res", i), r, vt[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
    end

    // consumer stalls for 5 cycles with the result pending
    launch(0, M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(0, lat);
    chk("hold_lat", lat, 34);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_result", b1.result, 32'hFFFF_FFFE);
      chk("hold_out_valid", b1.out_valid, 1);
      chk("hold_in_ready", b1.in_ready, 0);
    end
    take(0);
    chk("hold_after_take_in_ready", b1.in_ready, 1);

    // flush in the middle of CALC
    launch(0, M_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    b1.flush = 1;
    @(posedge clk);
    #1;
    b1.flush = 0;
    chk("flush_in_ready", b1.in_ready, 1);
    chk("flush_out_valid", b1.out_valid, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (b1.out_valid) seen = 1;
    end
    chk("flush_no_result", seen, 0);
    run(0, M_DIVU, 32'd9, 32'd3, r, lat);
    chk("post_flush_res", r, 3);
    chk("post_flush_lat", lat, 34);

    // flush beats a simultaneous request in IDLE
    @(negedge clk);
    b1.func3 = M_DIV; b1.rs1 = 32'd5; b1.rs2 = 32'd0;
    b1.in_valid = 1; b1.flush = 1;
    @(posedge clk);
    #1;
    b1.in_valid = 0;
    b1.flush = 0;
    chk("flush_req_out_valid", b1.out_valid, 0);
    chk("flush_req_in_ready", b1.in_ready, 1);
    @(posedge clk);
    #1;
    chk("flush_req_out_valid2", b1.out_valid, 0);

    rand_ops(0, 32, 30);

    run(1, M_MULHU, 32'hFFFF_FFFF, 32'd2, r, lat);
    chk("u4_mulhu_res", r, 1);
    chk("u4_mulhu_lat", lat, 10);

    // asynchronous reset mid-CALC, between clock edges
    launch(1, M_MUL, 32'd123, 32'd456);
    repeat (3) @(posedge clk);
    #2;
    rstn4 = 0;
    #1;
    chk("arst_out_valid", b4.out_valid, 0);
    chk("arst_in_ready", b4.in_ready, 1);
    chk("arst_result", b4.result, 0);
    @(negedge clk);
    rstn4 = 1;
    run(1, M_DIV, 32'hFFFF_FFF9, 32'd2, r, lat);
    chk("u4_after_rst_res", r, 32'hFFFF_FFFD);
    chk("u4_after_rst_lat", lat, 10);

    rand_ops(1, 8, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
